ddr_app_wr_bridge: RTL and testbench

Write-path bridge between the application traffic generator and the DDR controller's native command/write-data port. It collects application write words (`app_data_wr`/`app_data_wr_valid`) into a data FIFO. On each write-address pulse (`app_addr_wr_valid`) it closes the current burst and queues {address, length}. It then drains each queued burst to the controller as one write command followed by its data beats.

---
 rtl/ddr_app_wr_bridge.sv | 177 +++++++++++++++++
 tb/tb_ddr_app_wr_bridge.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ddr_app_wr_bridge.sv
// Write-path bridge: gathers application write words into bursts and replays each
// burst to the DDR controller's native port as one write command plus data beats.
module ddr_app_wr_bridge #(
  parameter int ADDR_WIDTH = 30,
  parameter int DATA_WIDTH = 32,
  parameter int BURST_MAX  = 64,
  parameter int DATA_DEPTH = 128,
  parameter int CMD_DEPTH  = 4
) (
  input  logic                  app_clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] app_data_wr,
  input  logic                  app_data_wr_valid,
  input  logic [ADDR_WIDTH-1:0] app_addr_wr,
  input  logic                  app_addr_wr_valid,
  output logic                  app_wr_ready,
  output logic                  mem_cmd_en,
  output logic [2:0]            mem_cmd,
  output logic [ADDR_WIDTH-1:0] mem_cmd_addr,
  output logic [7:0]            mem_cmd_bl,
  input  logic                  mem_cmd_rdy,
  output logic [DATA_WIDTH-1:0] mem_wdf_data,
  output logic                  mem_wdf_wren,
  output logic                  mem_wdf_end,
  input  logic                  mem_wdf_rdy,
  output logic                  burst_done,
  output logic [31:0]           burst_cnt,
  output logic                  err_overflow,
  output logic                  err_empty_burst
);

  localparam int DAW = $clog2(DATA_DEPTH);
  localparam int DCW = DAW + 1;
  localparam int CAW = $clog2(CMD_DEPTH);
  localparam int CCW = CAW + 1;
  localparam int LW  = $clog2(BURST_MAX) + 1;

  typedef enum logic [1:0] {IDLE, CMD, DATA} state_t;

  state_t state, state_nxt;

  logic [DATA_WIDTH-1:0] d_mem [DATA_DEPTH];
  logic [DAW-1:0]        d_wptr, d_rptr, d_wptr_nxt;
  logic [DCW-1:0]        d_count, d_count_nxt;
  logic                  d_full, d_empty, d_push, d_pop;

  logic [ADDR_WIDTH-1:0] c_addr_mem [CMD_DEPTH];
  logic [7:0]            c_bl_mem [CMD_DEPTH];
  logic [CAW-1:0]        c_wptr, c_rptr;
  logic [CCW-1:0]        c_count, c_count_nxt;
  logic                  c_full, c_empty, c_push, c_pop;

  logic [LW-1:0]         open_len, eff_len, eff_len_m1;
  logic                  word_drop, close_req, rewind, empty_close;

  logic [ADDR_WIDTH-1:0] cmd_addr;
  logic [7:0]            cmd_bl;
  logic [7:0]            beat;
  logic                  end_xfer;

  assign d_full  = d_count == DCW'(DATA_DEPTH);
  assign d_empty = d_count == '0;
  assign c_full  = c_count == CCW'(CMD_DEPTH);
  assign c_empty = c_count == '0;

  // A full FIFO still takes a word when the egress side frees a slot the same cycle.
  assign d_push    = app_data_wr_valid && (!d_full || d_pop) && (open_len != LW'(BURST_MAX));
  assign word_drop = app_data_wr_valid && !d_push;

  // The word arriving with the address strobe belongs to the burst being closed.
  assign eff_len     = open_len + LW'(d_push);
  assign eff_len_m1  = eff_len - LW'(1);
  assign close_req   = app_addr_wr_valid && (eff_len != '0);
  assign empty_close = app_addr_wr_valid && (eff_len == '0);
  assign c_push      = close_req && (!c_full || c_pop);
  assign rewind      = close_req && !c_push;

  // A lost descriptor orphans its words, so they are peeled back off the FIFO tail.
  assign d_wptr_nxt  = rewind ? d_wptr - DAW'(open_len) : d_wptr + DAW'(d_push);
  assign d_count_nxt = d_count + DCW'(d_push) - DCW'(d_pop) - (rewind ? DCW'(eff_len) : '0);
  assign c_count_nxt = c_count + CCW'(c_push) - CCW'(c_pop);

  assign d_pop    = mem_wdf_wren && mem_wdf_rdy;
  assign end_xfer = mem_wdf_end && mem_wdf_rdy;

  assign mem_cmd      = 3'b000;
  assign mem_cmd_addr = cmd_addr;
  assign mem_cmd_bl   = cmd_bl;
  assign mem_wdf_data = mem_wdf_wren ? d_mem[d_rptr] : '0;

  always_ff @(posedge app_clk) begin
    if (d_push) d_mem[d_wptr] <= app_data_wr;
    if (c_push) begin
      c_addr_mem[c_wptr] <= app_addr_wr;
      c_bl_mem[c_wptr]   <= 8'(eff_len_m1);
    end
  end

  always_ff @(posedge app_clk or negedge rst_n) begin
    if (!rst_n) begin
      d_wptr          <= '0;
      d_rptr          <= '0;
      d_count         <= '0;
      c_wptr          <= '0;
      c_rptr          <= '0;
      c_count         <= '0;
      open_len        <= '0;
      err_overflow    <= 1'b0;
      err_empty_burst <= 1'b0;
      app_wr_ready    <= 1'b0;
    end else begin
      d_wptr   <= d_wptr_nxt;
      d_count  <= d_count_nxt;
      c_count  <= c_count_nxt;
      open_len <= app_addr_wr_valid ? '0 : open_len + LW'(d_push);
      if (d_pop)  d_rptr <= d_rptr + DAW'(1);
      if (c_push) c_wptr <= c_wptr + CAW'(1);
      if (c_pop)  c_rptr <= c_rptr + CAW'(1);
      if (word_drop || rewind) err_overflow <= 1'b1;
      if (empty_close) err_empty_burst <= 1'b1;
      app_wr_ready <= (DCW'(DATA_DEPTH) - d_count_nxt >= DCW'(BURST_MAX)) &&
                      (c_count_nxt != CCW'(CMD_DEPTH));
    end
  end

  always_ff @(posedge app_clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt    = state;
    mem_cmd_en   = 1'b0;
    mem_wdf_wren = 1'b0;
    mem_wdf_end  = 1'b0;
    c_pop        = 1'b0;
    case (state)
      IDLE: begin
        if (!c_empty) begin
          c_pop     = 1'b1;
          state_nxt = CMD;
        end
      end
      CMD: begin
        mem_cmd_en = 1'b1;
        if (mem_cmd_rdy) state_nxt = DATA;
      end
      DATA: begin
        mem_wdf_wren = !d_empty;
        mem_wdf_end  = !d_empty && (beat == cmd_bl);
        if (mem_wdf_end && mem_wdf_rdy) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Descriptor and beat tracking; the command fields stay frozen until the next pop.
  always_ff @(posedge app_clk or negedge rst_n) begin
    if (!rst_n) begin
      cmd_addr   <= '0;
      cmd_bl     <= '0;
      beat       <= '0;
      burst_done <= 1'b0;
      burst_cnt  <= '0;
    end else begin
      burst_done <= end_xfer;
      if (end_xfer) burst_cnt <= burst_cnt + 32'd1;
      if (c_pop) begin
        cmd_addr <= c_addr_mem[c_rptr];
        cmd_bl   <= c_bl_mem[c_rptr];
      end
      if (state == CMD && mem_cmd_rdy) beat <= '0;
      else if (d_pop)                  beat <= beat + 8'd1;
    end
  end

endmodule

// File: tb/tb_ddr_app_wr_bridge.sv
// Directed bench for ddr_app_wr_bridge: burst replay, backpressure, queueing,
// error flags and mid-burst reset, with hand-computed expectations.
module tb_ddr_app_wr_bridge;

  logic        app_clk;
  logic        rst_n;
  logic [31:0] app_data_wr;
  logic        app_data_wr_valid;
  logic [29:0] app_addr_wr;
  logic        app_addr_wr_valid;
  logic        app_wr_ready;
  logic        mem_cmd_en;
  logic [2:0]  mem_cmd;
  logic [29:0] mem_cmd_addr;
  logic [7:0]  mem_cmd_bl;
  logic        mem_cmd_rdy;
  logic [31:0] mem_wdf_data;
  logic        mem_wdf_wren;
  logic        mem_wdf_end;
  logic        mem_wdf_rdy;
  logic        burst_done;
  logic [31:0] burst_cnt;
  logic        err_overflow;
  logic        err_empty_burst;

  int checks = 0;
  int errors = 0;

  logic [31:0] beat_q[$];
  bit          end_q[$];
  logic [29:0] cmd_addr_q[$];
  logic [7:0]  cmd_bl_q[$];
  int          done_cnt = 0;

  ddr_app_wr_bridge dut (
    .app_clk(app_clk),
    .rst_n(rst_n),
    .app_data_wr(app_data_wr),
    .app_data_wr_valid(app_data_wr_valid),
    .app_addr_wr(app_addr_wr),
    .app_addr_wr_valid(app_addr_wr_valid),
    .app_wr_ready(app_wr_ready),
    .mem_cmd_en(mem_cmd_en),
    .mem_cmd(mem_cmd),
    .mem_cmd_addr(mem_cmd_addr),
    .mem_cmd_bl(mem_cmd_bl),
    .mem_cmd_rdy(mem_cmd_rdy),
    .mem_wdf_data(mem_wdf_data),
    .mem_wdf_wren(mem_wdf_wren),
    .mem_wdf_end(mem_wdf_end),
    .mem_wdf_rdy(mem_wdf_rdy),
    .burst_done(burst_done),
    .burst_cnt(burst_cnt),
    .err_overflow(err_overflow),
    .err_empty_burst(err_empty_burst)
  );

  initial app_clk = 1'b0;
  always #5 app_clk = ~app_clk;

  // Record controller-side traffic mid-cycle, when every signal has settled.
  always @(negedge app_clk) begin
    if (rst_n) begin
      if (mem_wdf_wren && mem_wdf_rdy) begin
        beat_q.push_back(mem_wdf_data);
        end_q.push_back(mem_wdf_end);
      end
      if (mem_cmd_en && mem_cmd_rdy) begin
        cmd_addr_q.push_back(mem_cmd_addr);
        cmd_bl_q.push_back(mem_cmd_bl);
      end
      if (burst_done) done_cnt++;
    end
  end

  task automatic tick();
    @(posedge app_clk);
    #1;
  endtask

  task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push_burst(input logic [31:0] base, input int n, input logic [29:0] addr, input bit same);
    for (int i = 0; i < n; i++) begin
      app_data_wr       = base + i;
      app_data_wr_valid = 1'b1;
      if (same && i == n - 1) begin
        app_addr_wr       = addr;
        app_addr_wr_valid = 1'b1;
      end
      tick();
    end
    app_data_wr_valid = 1'b0;
    app_addr_wr_valid = 1'b0;
    if (!same) begin
      app_addr_wr       = addr;
      app_addr_wr_valid = 1'b1;
      tick();
      app_addr_wr_valid = 1'b0;
    end
  endtask

  task automatic wait_done(input string tag, input logic [31:0] target, input int budget, input bit toggle);
    for (int c = 0; c < budget && burst_cnt !== target; c++) begin
      if (toggle) mem_wdf_rdy = ~mem_wdf_rdy;
      tick();
    end
    check_output(tag, burst_cnt, target);
  endtask

  task automatic check_beats(input string tag, input int start, input int n, input int seg,
                             input logic [31:0] base, input logic [31:0] step);
    check_output({tag, "_count"}, beat_q.size() - start, n);
    for (int i = 0; i < n && start + i < beat_q.size(); i++) begin
      check_output({tag, "_data"}, beat_q[start + i], base + step * (i / seg) + (i % seg));
      check_output({tag, "_end"}, end_q[start + i], (i % seg) == seg - 1);
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed timeout expected completion");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int b0, c0, d0;
    bit stable;

    rst_n = 1'b0;
    app_data_wr = '0;
    app_data_wr_valid = 1'b0;
    app_addr_wr = '0;
    app_addr_wr_valid = 1'b0;
    mem_cmd_rdy = 1'b0;
    mem_wdf_rdy = 1'b0;

    // Reset state
    #2;
    check_output("rst_ready", app_wr_ready, 0);
    check_output("rst_cmd_en", mem_cmd_en, 0);
    check_output("rst_cmd", mem_cmd, 0);
    check_output("rst_wren", mem_wdf_wren, 0);
    check_output("rst_cnt", burst_cnt, 0);
    check_output("rst_errs", {err_overflow, err_empty_burst}, 0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    check_output("rst_ready_after", app_wr_ready, 1);

    // Single burst with command backpressure
    $display("[TB] single burst, command backpressure");
    b0 = beat_q.size();
    d0 = done_cnt;
    push_burst(32'h1, 32, 30'h80, 1'b0);
    check_output("lat_cmd_en_n1", mem_cmd_en, 0);
    tick();
    check_output("lat_cmd_en_n2", mem_cmd_en, 1);
    check_output("cmd_addr", mem_cmd_addr, 30'h80);
    check_output("cmd_bl", mem_cmd_bl, 31);
    stable = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (mem_cmd_en !== 1'b1 || mem_cmd_addr !== 30'h80 || mem_cmd_bl !== 8'd31 || mem_wdf_wren !== 1'b0)
        stable = 1'b0;
    end
    check_output("cmd_hold_stable", stable, 1);
    mem_cmd_rdy = 1'b1;
    mem_wdf_rdy = 1'b1;
    tick();
    check_output("first_wren", mem_wdf_wren, 1);
    check_output("first_data", mem_wdf_data, 32'h1);
    check_output("cmd_en_dropped", mem_cmd_en, 0);
    wait_done("burst1_done", 1, 100, 1'b0);
    check_output("burst_done_pulse", burst_done, 1);
    tick();
    check_output("burst_done_clear", burst_done, 0);
    check_output("burst1_done_count", done_cnt - d0, 1);
    check_beats("burst1", b0, 32, 32, 32'h1, 0);

    // Data backpressure: mem_wdf_rdy toggles every cycle
    $display("[TB] data backpressure");
    b0 = beat_q.size();
    c0 = cmd_addr_q.size();
    mem_wdf_rdy = 1'b0;
    push_burst(32'h100, 32, 30'h200, 1'b0);
    wait_done("burst2_done", 2, 200, 1'b1);
    mem_wdf_rdy = 1'b1;
    check_output("burst2_cmd_addr", cmd_addr_q[c0], 30'h200);
    check_output("burst2_cmd_bl", cmd_bl_q[c0], 31);
    check_beats("burst2", b0, 32, 32, 32'h100, 0);

    // Four same-cycle-closed bursts queued behind a stalled command port
    $display("[TB] queued bursts");
    b0 = beat_q.size();
    c0 = cmd_addr_q.size();
    mem_cmd_rdy = 1'b0;
    for (int k = 0; k < 4; k++)
      push_burst(32'h1000 * (k + 1), 20, 30'h1000 + 30'(k) * 30'h40, 1'b1);
    tick();
    tick();
    check_output("queue_ready_low", app_wr_ready, 0);
    check_output("queue_cmd_en", mem_cmd_en, 1);
    check_output("queue_cmd_addr", mem_cmd_addr, 30'h1000);
    mem_cmd_rdy = 1'b1;
    wait_done("queue_done", 6, 400, 1'b0);
    check_output("queue_cmd_count", cmd_addr_q.size() - c0, 4);
    for (int k = 0; k < 4 && c0 + k < cmd_addr_q.size(); k++) begin
      check_output("queue_cmd_addr_k", cmd_addr_q[c0 + k], 30'h1000 + 30'(k) * 30'h40);
      check_output("queue_cmd_bl_k", cmd_bl_q[c0 + k], 19);
    end
    check_beats("queue", b0, 80, 20, 32'h1000, 32'h1000);
    tick();
    check_output("queue_ready_high", app_wr_ready, 1);

    // Address strobe with no open words
    $display("[TB] empty burst");
    c0 = cmd_addr_q.size();
    app_addr_wr = 30'h3F0;
    app_addr_wr_valid = 1'b1;
    tick();
    app_addr_wr_valid = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    check_output("empty_err", err_empty_burst, 1);
    check_output("empty_no_ovf", err_overflow, 0);
    check_output("empty_no_cmd", cmd_addr_q.size() - c0, 0);
    check_output("empty_cmd_en", mem_cmd_en, 0);

    // 65 words into a 64-word burst limit
    $display("[TB] burst overflow");
    b0 = beat_q.size();
    c0 = cmd_addr_q.size();
    push_burst(32'h5000, 65, 30'h300, 1'b0);
    check_output("ovf_err", err_overflow, 1);
    wait_done("ovf_done", 7, 200, 1'b0);
    check_output("ovf_cmd_addr", cmd_addr_q[c0], 30'h300);
    check_output("ovf_cmd_bl", cmd_bl_q[c0], 63);
    check_beats("ovf", b0, 64, 64, 32'h5000, 0);

    // Reset while a burst is streaming
    $display("[TB] reset mid-burst");
    mem_wdf_rdy = 1'b0;
    push_burst(32'h7000, 32, 30'h400, 1'b0);
    for (int c = 0; c < 20 && mem_wdf_wren !== 1'b1; c++) tick();
    check_output("mid_wren_reached", mem_wdf_wren, 1);
    mem_wdf_rdy = 1'b1;
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    check_output("mid_rst_wren", mem_wdf_wren, 0);
    check_output("mid_rst_data", mem_wdf_data, 0);
    check_output("mid_rst_end", mem_wdf_end, 0);
    check_output("mid_rst_cmd_en", mem_cmd_en, 0);
    check_output("mid_rst_cmd_fields", {mem_cmd_addr, mem_cmd_bl}, 0);
    check_output("mid_rst_cnt", burst_cnt, 0);
    check_output("mid_rst_errs", {err_overflow, err_empty_burst}, 0);
    check_output("mid_rst_ready", app_wr_ready, 0);
    tick();
    rst_n = 1'b1;
    tick();
    check_output("post_rst_ready", app_wr_ready, 1);
    for (int i = 0; i < 4; i++) tick();
    check_output("post_rst_idle", {mem_cmd_en, mem_wdf_wren}, 0);
    b0 = beat_q.size();
    c0 = cmd_addr_q.size();
    push_burst(32'hABC, 1, 30'h40, 1'b0);
    wait_done("post_rst_done", 1, 50, 1'b0);
    check_output("post_rst_cmd_bl", cmd_bl_q[c0], 0);
    check_beats("post_rst", b0, 1, 1, 32'hABC, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
